// File: rtl/ws_feeder_if.sv
// ws_feeder_if: bundle of every non-clock/reset signal of the ws_feeder
// sequencer.
//   master : the feeder side. Drives busy/done, the weight and image read
//            ports, and the array-facing outputs.
//   slave  : the environment side. Drives the job control inputs and the
//            read data coming back from the memories.
// Signal groups:
//   job control   : start, img_base, wt_base -> busy, done
//   weight memory : wt_rd, wt_addr -> wt_data (1-cycle latency)
//   image memory  : img_rd[K], img_addr[K] -> img_data[K] (banked, 1-cycle)
//   PE array      : w_flat, bias, load_w, x_flat, en, clr, win_last
interface ws_feeder_if #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 10
);
    logic                      start;
    logic [ADDR_W-1:0]         img_base;
    logic [ADDR_W-1:0]         wt_base;
    logic                      busy;
    logic                      done;

    logic                      wt_rd;
    logic [ADDR_W-1:0]         wt_addr;
    logic [DATA_W-1:0]         wt_data;

    logic [K-1:0]              img_rd;
    logic [K*ADDR_W-1:0]       img_addr;
    logic [K*DATA_W-1:0]       img_data;

    logic [K*K*DATA_W-1:0]     w_flat;
    logic [DATA_W-1:0]         bias;
    logic                      load_w;
    logic [K*DATA_W-1:0]       x_flat;
    logic                      en;
    logic                      clr;
    logic                      win_last;

    modport master (
        input  start, img_base, wt_base, wt_data, img_data,
        output busy, done, wt_rd, wt_addr, img_rd, img_addr,
               w_flat, bias, load_w, x_flat, en, clr, win_last
    );

    modport slave (
        output start, img_base, wt_base, wt_data, img_data,
        input  busy, done, wt_rd, wt_addr, img_rd, img_addr,
               w_flat, bias, load_w, x_flat, en, clr, win_last
    );
endinterface

// File: rtl/ws_feeder.sv
// ws_feeder: job sequencer for the weight-stationary PE array.
// On an accepted start it reads K*K kernel words plus one bias word from
// weight memory, pulses load_w, then walks every convolution window of an
// IMG_W x IMG_W image, feeding kernel row i of each window into lane i with
// an i-cycle skew. Lanes carry zero whenever they hold no valid read data.
// Ports:
//   sys_clk : clock
//   rst     : synchronous active-high reset
//   bus     : ws_feeder_if.master (job control, memory reads, array outputs)
// Requires K >= 2.
module ws_feeder #(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 5,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 10
) (
    input  logic          sys_clk,
    input  logic          rst,
    ws_feeder_if.master   bus
);
    localparam int OUT_W    = (IMG_W - K) / STRIDE + 1;
    localparam int N_WIN    = OUT_W * OUT_W;
    localparam int N_STREAM = N_WIN * K;
    localparam int N_WT     = K * K + 1;
    localparam int CNT_MAX  = (N_STREAM > N_WT + 1) ? N_STREAM : N_WT + 1;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int J_W      = $clog2(K + 1);
    localparam int C_W      = $clog2(OUT_W + 1);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] LANE_STEP = ADDR_W'(IMG_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] img_base_q, img_base_d;
    logic [ADDR_W-1:0] wt_base_q, wt_base_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [C_W-1:0]    c_q, c_d;
    logic [ADDR_W-1:0] win_addr_q, win_addr_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic              done_q, done_d;
    logic              wrd_dly_q, wrd_dly_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic [DATA_W-1:0] w_q [K*K];
    logic [DATA_W-1:0] w_d [K*K];
    logic [DATA_W-1:0] bias_q, bias_d;

    // Skew shift register: entry i-1 holds what lane i presents this cycle.
    logic [ADDR_W-1:0] sr_addr_q [K-1];
    logic [ADDR_W-1:0] sr_addr_d [K-1];
    logic [K-2:0]      sr_vld_q, sr_vld_d;
    logic [K-2:0]      sr_last_q, sr_last_d;

    // Per-lane "read issued last cycle" flags; they gate x_flat and form en.
    logic [K-1:0]      rd_dly_q, rd_dly_d;
    logic              win_last_q, win_last_d;

    logic              wt_rd;
    logic [K-1:0]      lane_vld;
    logic [K-1:0]      lane_last;
    logic [ADDR_W-1:0] lane_addr [K];

    // Reads are issued for cnt 0..K*K; the extra LOAD_W cycle waits for the
    // bias word to come back before LATCH.
    assign wt_rd       = (state_q == S_LOAD_W) && (cnt_q <= CNT_W'(K * K));
    assign bus.wt_rd   = wt_rd;
    assign bus.wt_addr = wt_rd ? (wt_base_q + ADDR_W'(cnt_q)) : '0;

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.load_w   = (state_q == S_LATCH);
    assign bus.clr      = (state_q == S_IDLE) || (state_q == S_LOAD_W) || (state_q == S_LATCH);
    assign bus.en       = |rd_dly_q;
    assign bus.win_last = win_last_q;
    assign bus.bias     = bias_q;

    // Lane 0 is generated directly from the window walker.
    assign lane_vld[0]  = (state_q == S_STREAM);
    assign lane_last[0] = lane_vld[0] && (j_q == J_W'(K - 1));
    assign lane_addr[0] = win_addr_q + ADDR_W'(j_q);

    genvar gi;
    generate
        for (gi = 1; gi < K; gi++) begin : g_skew
            assign lane_vld[gi]  = sr_vld_q[gi-1];
            assign lane_last[gi] = sr_last_q[gi-1];
            assign lane_addr[gi] = sr_addr_q[gi-1];
        end

        for (gi = 0; gi < K; gi++) begin : g_lane
            assign bus.img_rd[gi] = lane_vld[gi];
            assign bus.img_addr[gi*ADDR_W +: ADDR_W] = lane_vld[gi] ? lane_addr[gi] : '0;
            assign bus.x_flat[gi*DATA_W +: DATA_W] =
                rd_dly_q[gi] ? bus.img_data[gi*DATA_W +: DATA_W] : '0;
        end

        for (gi = 0; gi < K*K; gi++) begin : g_wflat
            assign bus.w_flat[gi*DATA_W +: DATA_W] = w_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        img_base_d = img_base_q;
        wt_base_d  = wt_base_q;
        j_d        = j_q;
        c_d        = c_q;
        win_addr_d = win_addr_q;
        row_addr_d = row_addr_q;
        done_d     = 1'b0;
        w_d        = w_q;
        bias_d     = bias_q;

        // Weight capture: the word returned this cycle belongs to the read
        // index remembered from last cycle.
        wrd_dly_d = wt_rd;
        widx_d    = cnt_q;
        if (wrd_dly_q) begin
            for (int k = 0; k < K*K; k++) begin
                if (widx_q == CNT_W'(k)) begin
                    w_d[k] = bus.wt_data;
                end
            end
            if (widx_q == CNT_W'(K * K)) begin
                bias_d = bus.wt_data;
            end
        end

        // Lane i+1 repeats lane i one cycle later, one image row further down.
        for (int i = 0; i < K-1; i++) begin
            sr_vld_d[i]  = lane_vld[i];
            sr_last_d[i] = lane_last[i];
            sr_addr_d[i] = lane_addr[i] + LANE_STEP;
        end
        rd_dly_d   = lane_vld;
        win_last_d = lane_last[K-1];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    img_base_d = bus.img_base;
                    wt_base_d  = bus.wt_base;
                    cnt_d      = '0;
                    state_d    = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K * K + 1)) begin
                    cnt_d   = '0;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                cnt_d      = '0;
                j_d        = '0;
                c_d        = '0;
                win_addr_d = img_base_q;
                row_addr_d = img_base_q;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (j_q == J_W'(K - 1)) begin
                    j_d = '0;
                    if (c_q == C_W'(OUT_W - 1)) begin
                        // Next window row: both pointers jump to the new row start.
                        c_d        = '0;
                        row_addr_d = row_addr_q + ROW_STEP;
                        win_addr_d = row_addr_q + ROW_STEP;
                    end else begin
                        c_d        = c_q + C_W'(1);
                        win_addr_d = win_addr_q + COL_STEP;
                    end
                end else begin
                    j_d = j_q + J_W'(1);
                end
                if (cnt_q == CNT_W'(N_STREAM - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // K-1 cycles for the skewed lanes to issue their last reads,
                // plus one for the final data to reach x_flat.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            img_base_q <= '0;
            wt_base_q  <= '0;
            j_q        <= '0;
            c_q        <= '0;
            win_addr_q <= '0;
            row_addr_q <= '0;
            done_q     <= 1'b0;
            wrd_dly_q  <= 1'b0;
            widx_q     <= '0;
            for (int k = 0; k < K*K; k++) begin
                w_q[k] <= '0;
            end
            bias_q     <= '0;
            for (int i = 0; i < K-1; i++) begin
                sr_addr_q[i] <= '0;
            end
            sr_vld_q   <= '0;
            sr_last_q  <= '0;
            rd_dly_q   <= '0;
            win_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            img_base_q <= img_base_d;
            wt_base_q  <= wt_base_d;
            j_q        <= j_d;
            c_q        <= c_d;
            win_addr_q <= win_addr_d;
            row_addr_q <= row_addr_d;
            done_q     <= done_d;
            wrd_dly_q  <= wrd_dly_d;
            widx_q     <= widx_d;
            w_q        <= w_d;
            bias_q     <= bias_d;
            sr_addr_q  <= sr_addr_d;
            sr_vld_q   <= sr_vld_d;
            sr_last_q  <= sr_last_d;
            rd_dly_q   <= rd_dly_d;
            win_last_q <= win_last_d;
        end
    end
endmodule

// File: tb/tb_ws_feeder.sv
// Directed bench for ws_feeder. Two instances: dut0 with default geometry
// (IMG_W=5, STRIDE=1) and dut1 with IMG_W=7, STRIDE=2. Memories return
// wt_data = address+1 and img_data = address[7:0], so weights at wt_base=0
// are 1..9 with bias 10, and the image at img_base=0 is 0..24.
// Cycle n of a job is the n-th clock period after the edge that samples
// start; S (first STREAM cycle) is n=13 for K=3.
module tb_ws_feeder;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int AW = 10;
    localparam int NL = 128;

    logic sys_clk = 1'b0;
    logic rst;
    logic sel;
    int   checks   = 0;
    int   failures = 0;

    always #5 sys_clk = ~sys_clk;

    ws_feeder_if #(.DATA_W(DW), .K(K), .ADDR_W(AW)) b0 ();
    ws_feeder_if #(.DATA_W(DW), .K(K), .ADDR_W(AW)) b1 ();

    ws_feeder #(.DATA_W(DW), .K(K), .IMG_W(5), .STRIDE(1), .ADDR_W(AW)) dut0 (
        .sys_clk(sys_clk), .rst(rst), .bus(b0));
    ws_feeder #(.DATA_W(DW), .K(K), .IMG_W(7), .STRIDE(2), .ADDR_W(AW)) dut1 (
        .sys_clk(sys_clk), .rst(rst), .bus(b1));

    // Memory models, one-cycle read latency.
    always @(posedge sys_clk) begin
        if (b0.wt_rd) b0.wt_data <= DW'(b0.wt_addr + AW'(1));
        if (b1.wt_rd) b1.wt_data <= DW'(b1.wt_addr + AW'(1));
        for (int i = 0; i < K; i++) begin
            if (b0.img_rd[i]) b0.img_data[i*DW +: DW] <= b0.img_addr[i*AW +: DW];
            if (b1.img_rd[i]) b1.img_data[i*DW +: DW] <= b1.img_addr[i*AW +: DW];
        end
    end

    // Observed outputs of the instance under test.
    logic              m_busy, m_done, m_wt_rd, m_load_w, m_en, m_clr, m_wl;
    logic [AW-1:0]     m_wt_addr;
    logic [K-1:0]      m_img_rd;
    logic [K*AW-1:0]   m_img_addr;
    logic [K*DW-1:0]   m_x;
    logic [K*K*DW-1:0] m_w_flat;
    logic [DW-1:0]     m_bias;
    assign m_busy     = sel ? b1.busy     : b0.busy;
    assign m_done     = sel ? b1.done     : b0.done;
    assign m_wt_rd    = sel ? b1.wt_rd    : b0.wt_rd;
    assign m_load_w   = sel ? b1.load_w   : b0.load_w;
    assign m_en       = sel ? b1.en       : b0.en;
    assign m_clr      = sel ? b1.clr      : b0.clr;
    assign m_wl       = sel ? b1.win_last : b0.win_last;
    assign m_wt_addr  = sel ? b1.wt_addr  : b0.wt_addr;
    assign m_img_rd   = sel ? b1.img_rd   : b0.img_rd;
    assign m_img_addr = sel ? b1.img_addr : b0.img_addr;
    assign m_x        = sel ? b1.x_flat   : b0.x_flat;
    assign m_w_flat   = sel ? b1.w_flat   : b0.w_flat;
    assign m_bias     = sel ? b1.bias     : b0.bias;

    // Per-cycle log of one job.
    logic            lg_wt_rd  [NL];
    logic [AW-1:0]   lg_wt_addr[NL];
    logic            lg_load_w [NL];
    logic            lg_en     [NL];
    logic            lg_wl     [NL];
    logic            lg_busy   [NL];
    logic            lg_clr    [NL];
    logic [K-1:0]    lg_rd     [NL];
    logic [K*AW-1:0] lg_addr   [NL];
    logic [K*DW-1:0] lg_x      [NL];
    int              done_at;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_start(input logic s, input logic [AW-1:0] ib);
        if (sel) begin
            b1.start = s; b1.img_base = ib; b1.wt_base = '0;
        end else begin
            b0.start = s; b0.img_base = ib; b0.wt_base = '0;
        end
    endtask

    task automatic record(input int n);
        lg_wt_rd[n]   = m_wt_rd;
        lg_wt_addr[n] = m_wt_addr;
        lg_load_w[n]  = m_load_w;
        lg_en[n]      = m_en;
        lg_wl[n]      = m_wl;
        lg_busy[n]    = m_busy;
        lg_clr[n]     = m_clr;
        lg_rd[n]      = m_img_rd;
        lg_addr[n]    = m_img_addr;
        lg_x[n]       = m_x;
    endtask

    function automatic logic [AW-1:0] la(input int n, input int lane);
        logic [K*AW-1:0] v;
        v = lg_addr[n];
        return v[lane*AW +: AW];
    endfunction

    task automatic check_rst(input string tag);
        check({tag, "_busy"},     m_busy,     0);
        check({tag, "_done"},     m_done,     0);
        check({tag, "_wt_rd"},    m_wt_rd,    0);
        check({tag, "_wt_addr"},  m_wt_addr,  0);
        check({tag, "_img_rd"},   m_img_rd,   0);
        check({tag, "_img_addr"}, m_img_addr, 0);
        check({tag, "_w_flat"},   m_w_flat,   0);
        check({tag, "_bias"},     m_bias,     0);
        check({tag, "_load_w"},   m_load_w,   0);
        check({tag, "_x_flat"},   m_x,        0);
        check({tag, "_en"},       m_en,       0);
        check({tag, "_clr"},      m_clr,      1);
        check({tag, "_win_last"}, m_wl,       0);
    endtask

    // One job: start at the current cycle with base ib; optional start
    // pulses (img_base=500) at cycles p1/p2; optional reset at cycle rst_at.
    task automatic run_job(input logic [AW-1:0] ib, input int rst_at, input int p1, input int p2);
        for (int n = 0; n < NL; n++) begin
            lg_wt_rd[n] = 0; lg_wt_addr[n] = 0; lg_load_w[n] = 0; lg_en[n] = 0;
            lg_wl[n] = 0; lg_busy[n] = 0; lg_clr[n] = 0; lg_rd[n] = 0;
            lg_addr[n] = 0; lg_x[n] = 0;
        end
        done_at = -1;
        drive_start(1'b1, ib);
        step();
        drive_start(1'b0, ib);
        for (int n = 1; n < NL; n++) begin
            record(n);
            if (rst_at > 0 && n == rst_at + 1) check_rst("mid_rst");
            if (m_done === 1'b1) begin
                done_at = n;
                break;
            end
            if (rst_at > 0 && n >= rst_at + 10) break;
            drive_start(n == p1 || n == p2, AW'(500));
            rst = (n == rst_at);
            step();
        end
        drive_start(1'b0, AW'(500));
        rst = 1'b0;
    endtask

    // Timing and weight checks common to every full job (K=3, N_WIN=9).
    task automatic check_common(input string tag);
        int n_rd = 0, f_rd = -1, l_rd = -1;
        int n_lw = 0, f_lw = -1;
        int n_en = 0, f_en = -1, l_en = -1;
        int n_wl = 0, f_wl = -1;
        for (int n = 1; n < NL; n++) begin
            if (lg_wt_rd[n])  begin n_rd++; if (f_rd < 0) f_rd = n; l_rd = n; end
            if (lg_load_w[n]) begin n_lw++; if (f_lw < 0) f_lw = n; end
            if (lg_en[n])     begin n_en++; if (f_en < 0) f_en = n; l_en = n; end
            if (lg_wl[n])     begin n_wl++; if (f_wl < 0) f_wl = n; end
        end
        check({tag, "_wt_rd_count"},  n_rd, 10);
        check({tag, "_wt_rd_first"},  f_rd, 1);
        check({tag, "_wt_rd_last"},   l_rd, 10);
        check({tag, "_wt_addr_1"},    lg_wt_addr[1], 0);
        check({tag, "_wt_addr_10"},   lg_wt_addr[10], 9);
        check({tag, "_load_w_count"}, n_lw, 1);
        check({tag, "_load_w_at"},    f_lw, 12);
        check({tag, "_en_count"},     n_en, 29);
        check({tag, "_en_first"},     f_en, 14);
        check({tag, "_en_last"},      l_en, 42);
        check({tag, "_win_last_cnt"}, n_wl, 9);
        check({tag, "_win_last_1st"}, f_wl, 18);
        check({tag, "_done_at"},      done_at, 43);
        check({tag, "_busy_42"},      lg_busy[42], 1);
        check({tag, "_busy_43"},      lg_busy[43], 0);
        check({tag, "_clr_12"},       lg_clr[12], 1);
        check({tag, "_clr_13"},       lg_clr[13], 0);
        check({tag, "_clr_43"},       lg_clr[43], 1);
        check({tag, "_rd_42"},        lg_rd[42], 0);
        check({tag, "_w_flat"},       m_w_flat, 72'h09_08_07_06_05_04_03_02_01);
        check({tag, "_bias"},         m_bias, 10);
    endtask

    initial begin
        logic any_rd;
        sel = 1'b0;
        rst = 1'b1;
        b0.start = 0; b0.img_base = 0; b0.wt_base = 0;
        b1.start = 0; b1.img_base = 0; b1.wt_base = 0;
        repeat (3) step();
        check_rst("reset");
        rst = 1'b0;
        step();

        // Job 1: defaults, skew and window order.
        run_job(AW'(0), 0, 0, 0);
        check_common("j1");
        check("j1_l0_S",    la(13, 0), 0);
        check("j1_l0_S1",   la(14, 0), 1);
        check("j1_l0_S2",   la(15, 0), 2);
        check("j1_l1_S1",   la(14, 1), 5);
        check("j1_l1_S2",   la(15, 1), 6);
        check("j1_l1_S3",   la(16, 1), 7);
        check("j1_l2_S2",   la(15, 2), 10);
        check("j1_l2_S3",   la(16, 2), 11);
        check("j1_l2_S4",   la(17, 2), 12);
        check("j1_rd_S",    lg_rd[13], 3'b001);
        check("j1_rd_S1",   lg_rd[14], 3'b011);
        check("j1_x_S1",    lg_x[14], 24'h000000);
        check("j1_x_S2",    lg_x[15], 24'h000501);
        check("j1_x_S3",    lg_x[16], 24'h0A0602);
        check("j1_w4_a",    la(25, 0), 6);
        check("j1_w4_b",    la(26, 0), 7);
        check("j1_w4_c",    la(27, 0), 8);
        check("j1_w8_a",    la(39, 2), 22);
        check("j1_w8_b",    la(40, 2), 23);
        check("j1_w8_c",    la(41, 2), 24);

        // Job 2: back-to-back, start pulses while busy, address wrap.
        step();
        run_job(AW'(1020), 0, 3, 20);
        check_common("j2");
        check("j2_l0_S",    la(13, 0), 1020);
        check("j2_w1_l0",   la(16, 0), 1021);
        check("j2_wrap_l0", la(21, 0), 0);
        check("j2_wrap_l2", la(15, 2), 6);
        check("j2_x_S3",    lg_x[16], 24'h0602FE);

        // Job 3: reset at t=10 (cycle S+10), then no reads.
        step();
        run_job(AW'(0), 23, 0, 0);
        any_rd = 1'b0;
        for (int n = 24; n <= 33; n++) begin
            any_rd = any_rd | (|lg_rd[n]) | lg_busy[n];
        end
        check("rst_no_reads", any_rd, 0);

        // Job 4: full nominal job after the reset.
        step();
        run_job(AW'(0), 0, 0, 0);
        check_common("j4");
        check("j4_l0_S",  la(13, 0), 0);
        check("j4_l2_S4", la(17, 2), 12);

        // Job 5: STRIDE=2, IMG_W=7 instance.
        sel = 1'b1;
        step();
        run_job(AW'(0), 0, 0, 0);
        check_common("s2");
        check("s2_l1_S1", la(14, 1), 7);
        check("s2_w1_a",  la(16, 0), 2);
        check("s2_w1_b",  la(17, 0), 3);
        check("s2_w1_c",  la(18, 0), 4);
        check("s2_w3_a",  la(22, 0), 14);
        check("s2_w3_b",  la(23, 0), 15);
        check("s2_w3_c",  la(24, 0), 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
